// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// Instruction fetch stage: owns the PC and issues one-at-a-time word reads to
// imem. It presents each fetched word to decode over a valid/ready handshake.
// Latency: a request at t with imem_rdy at t+k gives inst_valid from t+k+1.
//   An accepted handshake produces the next request one cycle later.
// Backpressure: while inst_ready=0 the outputs hold and no new request issues.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   imem_req/imem_addr  one-cycle read request and its address
//   imem_rdy/imem_rdata single-cycle read response
//   inst_valid, instruction, inst_pc, pc_plus2, inst_ready, halt
//                       handshake with decode
//   redirect, redirect_pc
//                       control-flow change from execute
//   err, halted         misaligned-target flag and permanent-stop status
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [15:0] imem_rdata,
  output logic        inst_valid,
  output logic [15:0] instruction,
  output logic [15:0] inst_pc,
  output logic [15:0] pc_plus2,
  input  logic        inst_ready,
  input  logic        halt,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        err,
  output logic        halted
);

  localparam logic [1:0] REQ    = 2'd0;
  localparam logic [1:0] WAIT   = 2'd1;
  localparam logic [1:0] FULL   = 2'd2;
  localparam logic [1:0] HALTED = 2'd3;

  logic [1:0]  state;
  logic [15:0] pc;
  logic        kill;      // in-flight response belongs to a squashed fetch
  logic        armed;     // low for the first cycle out of reset so every output reads 0 in reset
  logic [15:0] instr_q;
  logic [15:0] inst_pc_q;
  logic [15:0] pc_plus2_q;
  logic        err_q;

  // Every output is decoded from registered state only.
  assign imem_req    = (state == REQ) && armed;
  assign imem_addr   = imem_req ? pc : 16'h0000;
  assign inst_valid  = (state == FULL);
  assign halted      = (state == HALTED);
  assign instruction = instr_q;
  assign inst_pc     = inst_pc_q;
  assign pc_plus2    = pc_plus2_q;
  assign err         = err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= REQ;
      pc         <= RESET_PC;
      kill       <= 1'b0;
      armed      <= 1'b0;
      instr_q    <= 16'h0000;
      inst_pc_q  <= 16'h0000;
      pc_plus2_q <= 16'h0000;
      err_q      <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (redirect && (state != HALTED)) begin
        // A redirect overrides every normal transition, including halt.
        pc <= redirect_pc;
        if (redirect_pc[0]) begin
          err_q <= 1'b1;
          kill  <= 1'b0;
          state <= HALTED;
        end else begin
          case (state)
            REQ: begin
              // If a request went out this cycle, its response is stale.
              if (armed) begin
                state <= WAIT;
                kill  <= 1'b1;
              end
            end
            WAIT: begin
              if (imem_rdy) begin
                state <= REQ;
                kill  <= 1'b0;
              end else begin
                kill  <= 1'b1;
              end
            end
            default: state <= REQ;   // FULL: the presented word is dropped
          endcase
        end
      end else begin
        case (state)
          REQ: begin
            if (armed) state <= WAIT;
          end
          WAIT: begin
            if (imem_rdy) begin
              if (kill) begin
                kill  <= 1'b0;
                state <= REQ;
              end else begin
                instr_q    <= imem_rdata;
                inst_pc_q  <= pc;
                pc_plus2_q <= pc + 16'd2;
                pc         <= pc + 16'd2;
                state      <= FULL;
              end
            end
          end
          FULL: begin
            if (inst_ready) state <= halt ? HALTED : REQ;
          end
          default: ;   // HALTED is left only through reset
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        inst_valid;
  logic [15:0] instruction;
  logic [15:0] inst_pc;
  logic [15:0] pc_plus2;
  logic        inst_ready;
  logic        halt;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        err;
  logic        halted;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int lat = 1;

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdy(imem_rdy), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .instruction(instruction),
    .inst_pc(inst_pc), .pc_plus2(pc_plus2),
    .inst_ready(inst_ready), .halt(halt),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .err(err), .halted(halted)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Program image: three fixed words, everything else a function of the address.
  function automatic logic [15:0] word_at(input logic [15:0] a);
    case (a)
      16'h0000: return 16'hA001;
      16'h0002: return 16'hA002;
      16'h0004: return 16'hA003;
      default:  return a ^ 16'h3C5A;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Variable-latency memory: answers each request exactly lat cycles later.
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [15:0] maddr = 16'h0000;
  always begin
    @(posedge clk);
    #2;
    imem_rdy = 1'b0;
    if (!rst) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          imem_rdy   = 1'b1;
          imem_rdata = word_at(maddr);
          pend       = 1'b0;
        end
      end
      if (imem_req === 1'b1) begin
        pend  = 1'b1;
        cnt   = lat;
        maddr = imem_addr;
      end
    end
  end

  // Transaction-level model: tracks which address is next in program order,
  // whether a fetch is outstanding and whether it was squashed.
  logic        model_on = 1'b0;
  logic        m_armed, m_req, m_valid, m_halted, m_err, outst, stale;
  logic        req_n, valid_n;
  logic [15:0] exp_pc;

  always @(negedge clk) begin
    if (model_on) begin
      chk1("imem_req", imem_req, m_req);
      chk1("inst_valid", inst_valid, m_valid);
      chk1("halted", halted, m_halted);
      chk1("err", err, m_err);
      if (m_req) chk("imem_addr", imem_addr, exp_pc);
      if (m_valid) begin
        chk("inst_pc", inst_pc, exp_pc);
        chk("instruction", instruction, word_at(exp_pc));
        chk("pc_plus2", pc_plus2, exp_pc + 16'd2);
      end
    end
    if (!rst) begin
      model_on = 1'b1;
      m_armed = 1'b0; m_req = 1'b0; m_valid = 1'b0;
      m_halted = 1'b0; m_err = 1'b0; outst = 1'b0; stale = 1'b0;
      exp_pc = 16'h0000;
    end else if (model_on) begin
      req_n   = 1'b0;
      valid_n = m_valid;
      if (!m_armed) begin
        m_armed = 1'b1;
        req_n   = 1'b1;
      end else if (!m_halted) begin
        if (redirect) begin
          valid_n = 1'b0;
          exp_pc  = redirect_pc;
          if (redirect_pc[0]) begin
            m_halted = 1'b1;
            m_err    = 1'b1;
          end else begin
            stale = (outst && !imem_rdy) || m_req;
            req_n = !stale;
          end
        end else begin
          if (imem_rdy && outst) begin
            if (stale) begin
              stale = 1'b0;
              req_n = 1'b1;
            end else begin
              valid_n = 1'b1;
            end
          end
          if (m_valid && inst_ready) begin
            valid_n = 1'b0;
            if (halt) m_halted = 1'b1;
            else begin
              req_n  = 1'b1;
              exp_pc = exp_pc + 16'd2;
            end
          end
        end
      end
      if (imem_rdy) outst = 1'b0;
      if (m_req) outst = 1'b1;
      m_req   = req_n;
      m_valid = valid_n;
    end
  end

  task automatic wait_for(input bit on_valid, input string nm);
    int n = 0;
    while (((on_valid ? inst_valid : imem_req) !== 1'b1) && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: no event within %0d cycles, expected one", nm, n);
    end
  endtask

  task automatic do_reset(input bit check_state);
    rst = 1'b0; redirect = 1'b0; halt = 1'b0; redirect_pc = 16'h0000;
    tick();
    tick();
    if (check_state) begin
      chk1("rst_imem_req", imem_req, 1'b0);
      chk("rst_imem_addr", imem_addr, 16'h0000);
      chk1("rst_inst_valid", inst_valid, 1'b0);
      chk("rst_instruction", instruction, 16'h0000);
      chk("rst_inst_pc", inst_pc, 16'h0000);
      chk("rst_pc_plus2", pc_plus2, 16'h0000);
      chk1("rst_err", err, 1'b0);
      chk1("rst_halted", halted, 1'b0);
    end
    tick();
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: still running at %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    int c0;
    int reqs;
    rst = 1'b0; inst_ready = 1'b1; halt = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;

    // Streaming with k=1 and ready tied high.
    lat = 1; inst_ready = 1'b1;
    do_reset(1'b1);
    wait_for(1'b1, "a_valid0");
    chk("a_instr0", instruction, 16'hA001);
    chk("a_pc0", inst_pc, 16'h0000);
    chk("a_pp0", pc_plus2, 16'h0002);
    c0 = cyc;
    tick();
    wait_for(1'b1, "a_valid1");
    chk("a_instr1", instruction, 16'hA002);
    chk("a_pc1", inst_pc, 16'h0002);
    chk("a_pp1", pc_plus2, 16'h0004);
    chk("a_gap1", 16'(cyc - c0), 16'd3);
    c0 = cyc;
    tick();
    wait_for(1'b1, "a_valid2");
    chk("a_instr2", instruction, 16'hA003);
    chk("a_pc2", inst_pc, 16'h0004);
    chk("a_pp2", pc_plus2, 16'h0006);
    chk("a_gap2", 16'(cyc - c0), 16'd3);

    // Backpressure.
    inst_ready = 1'b0;
    do_reset(1'b0);
    wait_for(1'b1, "b_valid");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1("b_hold_req", imem_req, 1'b0);
      chk1("b_hold_valid", inst_valid, 1'b1);
      chk("b_hold_instr", instruction, 16'hA001);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk1("b_next_req", imem_req, 1'b1);
    chk("b_next_addr", imem_addr, 16'h0002);

    // Redirect during WAIT with k=4.
    lat = 4; inst_ready = 1'b1;
    do_reset(1'b0);
    wait_for(1'b0, "c_req0");
    chk("c_addr0", imem_addr, 16'h0000);
    tick();
    redirect = 1'b1; redirect_pc = 16'h0040;
    tick();
    redirect = 1'b0;
    wait_for(1'b0, "c_req1");
    chk("c_addr1", imem_addr, 16'h0040);
    tick();
    wait_for(1'b1, "c_valid");
    chk("c_pc", inst_pc, 16'h0040);
    chk("c_instr", instruction, 16'h3C1A);
    chk("c_pp", pc_plus2, 16'h0042);

    // HALT on the instruction at 0x0006.
    lat = 1; inst_ready = 1'b0;
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) begin
      wait_for(1'b1, "d_valid");
      if (inst_pc == 16'h0006) break;
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
    end
    chk("d_pc", inst_pc, 16'h0006);
    chk("d_instr", instruction, 16'h3C5C);
    halt = 1'b1; inst_ready = 1'b1;
    tick();
    halt = 1'b0; inst_ready = 1'b0;
    chk1("d_halted", halted, 1'b1);
    chk1("d_valid_off", inst_valid, 1'b0);
    reqs = 0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req) reqs++;
      tick();
    end
    chk("d_reqs", 16'(reqs), 16'd0);
    redirect = 1'b1; redirect_pc = 16'h0040;
    tick();
    redirect = 1'b0;
    reqs = 0;
    for (int i = 0; i < 5; i++) begin
      if (imem_req) reqs++;
      tick();
    end
    chk("d_reqs_after_redirect", 16'(reqs), 16'd0);
    chk1("d_still_halted", halted, 1'b1);

    // Misaligned redirect, then recovery through reset.
    lat = 2; inst_ready = 1'b1;
    do_reset(1'b0);
    wait_for(1'b1, "e_valid");
    redirect = 1'b1; redirect_pc = 16'h0011;
    tick();
    redirect = 1'b0;
    chk1("e_err", err, 1'b1);
    chk1("e_halted", halted, 1'b1);
    reqs = 0;
    for (int i = 0; i < 5; i++) begin
      if (imem_req) reqs++;
      tick();
    end
    chk("e_reqs", 16'(reqs), 16'd0);
    rst = 1'b0;
    tick();
    tick();
    chk1("e_err_cleared", err, 1'b0);
    chk1("e_halted_cleared", halted, 1'b0);
    rst = 1'b1;
    wait_for(1'b0, "e_req");
    chk("e_restart_addr", imem_addr, 16'h0000);

    // Wrap-around, redirect and halt in the same handshake.
    lat = 1; inst_ready = 1'b0;
    do_reset(1'b0);
    wait_for(1'b1, "f_valid0");
    redirect = 1'b1; redirect_pc = 16'hFFFE; halt = 1'b1; inst_ready = 1'b1;
    tick();
    redirect = 1'b0; halt = 1'b0;
    chk1("f_not_halted", halted, 1'b0);
    wait_for(1'b1, "f_valid1");
    chk("f_pc", inst_pc, 16'hFFFE);
    chk("f_pp", pc_plus2, 16'h0000);
    chk("f_instr", instruction, 16'hC3A4);
    chk1("f_err", err, 1'b0);
    tick();
    wait_for(1'b0, "f_req");
    chk("f_wrap_addr", imem_addr, 16'h0000);

    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
